// File: rtl/clk_gen_multi.sv
// clk_gen_multi: multi-channel DDS clock generator with a lock/relock FSM
// and a valid/ready retune port. All logic runs on refclk.

// One output channel: phase accumulator plus registered square wave and wrap pulse.
module clk_gen_ch #(
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INCR = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             wr_i,     // load new incr/phase for this channel
  input  logic [ACC_W-1:0] incr_i,
  input  logic [ACC_W-1:0] phase_i,
  input  logic             run_i,    // locked, enabled and not being retuned
  output logic             outclk_o,
  output logic             ce_o
);
  logic [ACC_W-1:0] incr_q, phase_q, acc_q;
  logic [ACC_W:0]   sum_d;
  logic             outclk_q, ce_q;

  assign sum_d    = {1'b0, acc_q} + {1'b0, incr_q};
  assign outclk_o = outclk_q;
  assign ce_o     = ce_q;

  // Config registers; acc runs while enabled, otherwise parks at phase with outputs low.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      incr_q   <= DEFAULT_INCR;
      phase_q  <= '0;
      acc_q    <= '0;
      outclk_q <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      if (wr_i) begin
        incr_q  <= incr_i;
        phase_q <= phase_i;
      end
      if (run_i) begin
        acc_q    <= sum_d[ACC_W-1:0];
        ce_q     <= sum_d[ACC_W];
        outclk_q <= sum_d[ACC_W-1];
      end else begin
        acc_q    <= phase_q;
        ce_q     <= 1'b0;
        outclk_q <= 1'b0;
      end
    end
  end
endmodule

module clk_gen_multi #(
  parameter int               NUM_CH       = 2,
  parameter int               ACC_W        = 32,
  parameter int               LOCK_CYCLES  = 16,
  parameter logic [ACC_W-1:0] DEFAULT_INCR = 32'h3333_3334,
  localparam int              CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);
  localparam int              CNT_W    = $clog2(LOCK_CYCLES);
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic {LOCKING, LOCKED} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             locked_q;
  logic             accept, relock;

  // Out-of-range channels complete the handshake but change nothing.
  assign accept    = cfg_valid && locked_q;
  assign relock    = accept && ({1'b0, cfg_ch} < NUM_CH_L);
  assign cfg_ready = locked_q;
  assign locked    = locked_q;

  // Lock FSM: count LOCK_CYCLES after reset or a retune, then hold LOCKED.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= LOCKING;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        LOCKING: begin
          if (cnt_q == CNT_END) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (relock) begin
            state_q  <= LOCKING;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= LOCKING;
          cnt_q    <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  // The retune edge itself already stops every channel, so outputs are low
  // in the whole cycle that locked reads 0 and all channels restart aligned.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    clk_gen_ch #(
      .ACC_W        (ACC_W),
      .DEFAULT_INCR (DEFAULT_INCR)
    ) u_ch (
      .refclk   (refclk),
      .rst      (rst),
      .wr_i     (relock && (cfg_ch == CH_W'(gi))),
      .incr_i   (cfg_incr),
      .phase_i  (cfg_phase),
      .run_i    (locked_q && ch_en[gi] && !relock),
      .outclk_o (outclk[gi]),
      .ce_o     (ce[gi])
    );
  end
endmodule
